// File: rtl/reg_write_arbiter_if.sv
// Bus bundle for reg_write_arbiter: two writeback requesters, clear handshake
// and the registered register-file write port.
interface reg_write_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              alu_req;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              clear_req;
    logic              clear_done;

    logic              write;
    logic [ADDR_W-1:0] inaddress;
    logic [DATA_W-1:0] in_data;
    logic              busy;

    modport slave (
        input  alu_req, alu_addr, alu_data,
        input  mem_req, mem_addr, mem_data,
        input  clear_req,
        output alu_ready, mem_ready, clear_done,
        output write, inaddress, in_data, busy
    );

    modport master (
        output alu_req, alu_addr, alu_data,
        output mem_req, mem_addr, mem_data,
        output clear_req,
        input  alu_ready, mem_ready, clear_done,
        input  write, inaddress, in_data, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-slot register-file write arbiter (oldest first) with an optional
// clear-all sequence enabled by defining RWA_CLEAR_SEQ_EN.
module reg_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reg_write_arbiter_if.slave bus
);
`ifdef RWA_CLEAR_SEQ_EN
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);
`else
    typedef enum logic [0:0] {IDLE, DRAIN} state_t;
`endif

    state_t            state_q;
    logic              alu_valid_q, mem_valid_q;
    logic              older_q;          // 1: MEM entry was captured first
    logic [ADDR_W-1:0] alu_addr_q, mem_addr_q, inaddress_q;
    logic [DATA_W-1:0] alu_data_q, mem_data_q, in_q;
    logic              write_q;
    logic              clear_done_q;

    logic slot_block, clear_hold;
    logic alu_take, mem_take, grant_alu, grant_mem;
    logic alu_valid_d, mem_valid_d, older_d;

`ifdef RWA_CLEAR_SEQ_EN
    logic              clear_pending_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              clear_active, clear_accept;

    assign clear_active = (state_q == CLEAR) || (state_q == DONE);
    assign clear_accept = bus.clear_req && !clear_active;
    assign slot_block   = clear_pending_q | clear_active;
    assign clear_hold   = clear_pending_q | clear_accept;
`else
    logic unused_clear;
    assign unused_clear = ^{1'b0, bus.clear_req, NREG > 0};
    assign slot_block   = 1'b0;
    assign clear_hold   = 1'b0;
`endif

    assign bus.alu_ready  = ~alu_valid_q & ~slot_block;
    assign bus.mem_ready  = ~mem_valid_q & ~slot_block;
    assign bus.busy       = alu_valid_q | mem_valid_q | slot_block;
    assign bus.write      = write_q;
    assign bus.inaddress  = inaddress_q;
    assign bus.in_data    = in_q;
    assign bus.clear_done = clear_done_q;

    assign alu_take = bus.alu_req & bus.alu_ready;
    assign mem_take = bus.mem_req & bus.mem_ready;

    // Grants only look at entries held before this edge, so a fresh capture
    // always waits one edge before it can be written.
    assign grant_mem = mem_valid_q & (~alu_valid_q | older_q);
    assign grant_alu = alu_valid_q & ~grant_mem;

    assign alu_valid_d = alu_take | (alu_valid_q & ~grant_alu);
    assign mem_valid_d = mem_take | (mem_valid_q & ~grant_mem);

    always_comb begin
        older_d = older_q;
        if (alu_take && mem_take) begin
            older_d = 1'b1;
        end else if (alu_take) begin
            older_d = mem_valid_d;
        end else if (mem_take) begin
            older_d = ~alu_valid_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            alu_valid_q  <= 1'b0;
            mem_valid_q  <= 1'b0;
            older_q      <= 1'b0;
            alu_addr_q   <= '0;
            alu_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            write_q      <= 1'b0;
            inaddress_q  <= '0;
            in_q         <= '0;
            clear_done_q <= 1'b0;
`ifdef RWA_CLEAR_SEQ_EN
            clear_pending_q <= 1'b0;
            cnt_q           <= '0;
`endif
        end else begin
            alu_valid_q  <= alu_valid_d;
            mem_valid_q  <= mem_valid_d;
            older_q      <= older_d;
            write_q      <= 1'b0;
            clear_done_q <= 1'b0;

            if (alu_take) begin
                alu_addr_q <= bus.alu_addr;
                alu_data_q <= bus.alu_data;
            end
            if (mem_take) begin
                mem_addr_q <= bus.mem_addr;
                mem_data_q <= bus.mem_data;
            end

            if (grant_mem) begin
                write_q     <= 1'b1;
                inaddress_q <= mem_addr_q;
                in_q        <= mem_data_q;
            end else if (grant_alu) begin
                write_q     <= 1'b1;
                inaddress_q <= alu_addr_q;
                in_q        <= alu_data_q;
            end

`ifdef RWA_CLEAR_SEQ_EN
            if (clear_accept) begin
                clear_pending_q <= 1'b1;
            end
`endif

            case (state_q)
                IDLE, DRAIN: begin
`ifdef RWA_CLEAR_SEQ_EN
                    // The first zero write is issued on the entry edge.
                    if (clear_pending_q && !alu_valid_q && !mem_valid_q) begin
                        state_q         <= CLEAR;
                        clear_pending_q <= 1'b0;
                        cnt_q           <= '0;
                        write_q         <= 1'b1;
                        inaddress_q     <= '0;
                        in_q            <= '0;
                    end else
`endif
                    if (state_q == IDLE) begin
                        if (alu_valid_q || mem_valid_q) begin
                            state_q <= DRAIN;
                        end
                    end else if (!alu_valid_d && !mem_valid_d && !clear_hold) begin
                        state_q <= IDLE;
                    end
                end
`ifdef RWA_CLEAR_SEQ_EN
                CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q      <= DONE;
                        clear_done_q <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        write_q     <= 1'b1;
                        inaddress_q <= cnt_q + 1'b1;
                        in_q        <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter; clear-sequence tests
// run when RWA_CLEAR_SEQ_EN is defined, the disabled-clear test otherwise.
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    reg_write_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    reg_write_arbiter #(.DATA_W(8), .ADDR_W(3), .NREG(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.write === 1'b1) begin
            $display("write addr=%0d data=%h", bus.inaddress, bus.in_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_req   = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        bus.clear_req = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", bus.write); end
        checks++; if (bus.inaddress !== 3'd0) begin errors++; $display("FAIL reset_inaddress: got %0d expected 0", bus.inaddress); end
        checks++; if (bus.in_data !== 8'h00) begin errors++; $display("FAIL reset_in: got %h expected 00", bus.in_data); end
        checks++; if (bus.clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %b expected 0", bus.clear_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b expected 1", bus.alu_ready); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b expected 1", bus.mem_ready); end
        rst = 1'b0;
        step();
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL post_reset_write: got %b expected 0", bus.write); end
    endtask

    task automatic test_single();
        bus.alu_req = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 8'h5A;
        step();
        bus.alu_req = 1'b0;
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL single_ready_low: got %b expected 0", bus.alu_ready); end
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL single_no_early_write: got %b expected 0", bus.write); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        step();
        checks++; if (bus.write !== 1'b1) begin errors++; $display("FAIL single_write: got %b expected 1", bus.write); end
        checks++; if (bus.inaddress !== 3'd3) begin errors++; $display("FAIL single_addr: got %0d expected 3", bus.inaddress); end
        checks++; if (bus.in_data !== 8'h5A) begin errors++; $display("FAIL single_data: got %h expected 5a", bus.in_data); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b expected 1", bus.alu_ready); end
        step();
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL single_write_drop: got %b expected 0", bus.write); end
        checks++; if (bus.inaddress !== 3'd3) begin errors++; $display("FAIL single_addr_hold: got %0d expected 3", bus.inaddress); end
        checks++; if (bus.in_data !== 8'h5A) begin errors++; $display("FAIL single_data_hold: got %h expected 5a", bus.in_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_simultaneous();
        bus.alu_req = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'h11;
        bus.mem_req = 1'b1; bus.mem_addr = 3'd2; bus.mem_data = 8'h22;
        step();
        idle_inputs();
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL simul_no_write: got %b expected 0", bus.write); end
        checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin errors++; $display("FAIL simul_ready: got %b expected 00", {bus.alu_ready, bus.mem_ready}); end
        step();
        checks++; if ({bus.write, bus.inaddress, bus.in_data} !== {1'b1, 3'd2, 8'h22}) begin errors++; $display("FAIL simul_first_mem: got w=%b a=%0d d=%h expected w=1 a=2 d=22", bus.write, bus.inaddress, bus.in_data); end
        checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin errors++; $display("FAIL simul_ready_mid: got %b expected 01", {bus.alu_ready, bus.mem_ready}); end
        step();
        checks++; if ({bus.write, bus.inaddress, bus.in_data} !== {1'b1, 3'd2, 8'h11}) begin errors++; $display("FAIL simul_second_alu: got w=%b a=%0d d=%h expected w=1 a=2 d=11", bus.write, bus.inaddress, bus.in_data); end
        step();
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL simul_done: got %b expected 0", bus.write); end
    endtask

    task automatic test_mem_then_alu();
        bus.mem_req = 1'b1; bus.mem_addr = 3'd5; bus.mem_data = 8'h33;
        step();
        bus.mem_req = 1'b0;
        bus.alu_req = 1'b1; bus.alu_addr = 3'd6; bus.alu_data = 8'h44;
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL order_mem_ready: got %b expected 0", bus.mem_ready); end
        step();
        bus.alu_req = 1'b0;
        checks++; if ({bus.write, bus.inaddress, bus.in_data} !== {1'b1, 3'd5, 8'h33}) begin errors++; $display("FAIL order_mem_first: got w=%b a=%0d d=%h expected w=1 a=5 d=33", bus.write, bus.inaddress, bus.in_data); end
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL order_alu_captured: got %b expected 0", bus.alu_ready); end
        step();
        checks++; if ({bus.write, bus.inaddress, bus.in_data} !== {1'b1, 3'd6, 8'h44}) begin errors++; $display("FAIL order_alu_second: got w=%b a=%0d d=%h expected w=1 a=6 d=44", bus.write, bus.inaddress, bus.in_data); end
        step();
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL order_done: got %b expected 0", bus.write); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expect_w;
        expect_w = 4'b1010;
        bus.alu_req = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.write !== expect_w[i]) begin errors++; $display("FAIL b2b_write_%0d: got %b expected %b", i, bus.write, expect_w[i]); end
        end
        bus.alu_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_drain();
        bus.alu_req = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'hAA;
        bus.mem_req = 1'b1; bus.mem_addr = 3'd6; bus.mem_data = 8'hBB;
        step();
        idle_inputs();
        step();
        checks++; if ({bus.write, bus.in_data} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL drain_rst_pre: got w=%b d=%h expected w=1 d=bb", bus.write, bus.in_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL drain_rst_write: got %b expected 0", bus.write); end
        checks++; if ({bus.alu_ready, bus.mem_ready, bus.busy} !== 3'b110) begin errors++; $display("FAIL drain_rst_ready_busy: got %b expected 110", {bus.alu_ready, bus.mem_ready, bus.busy}); end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL drain_rst_after_%0d: got %b expected 0", i, bus.write); end
        end
    endtask

`ifdef RWA_CLEAR_SEQ_EN
    task automatic test_clear();
        bus.alu_req = 1'b1; bus.alu_addr = 3'd4; bus.alu_data = 8'h77;
        step();
        bus.alu_req = 1'b0;
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        checks++; if ({bus.write, bus.inaddress, bus.in_data} !== {1'b1, 3'd4, 8'h77}) begin errors++; $display("FAIL clear_alu_first: got w=%b a=%0d d=%h expected w=1 a=4 d=77", bus.write, bus.inaddress, bus.in_data); end
        checks++; if ({bus.alu_ready, bus.mem_ready, bus.busy} !== 3'b001) begin errors++; $display("FAIL clear_pending_ready: got %b expected 001", {bus.alu_ready, bus.mem_ready, bus.busy}); end
        for (int i = 0; i < 8; i++) begin
            bus.clear_req = (i == 2);
            step();
            checks++; if ({bus.write, bus.inaddress, bus.in_data} !== {1'b1, 3'(i), 8'h00}) begin errors++; $display("FAIL clear_write_%0d: got w=%b a=%0d d=%h expected w=1 a=%0d d=00", i, bus.write, bus.inaddress, bus.in_data, i); end
            checks++; if ({bus.alu_ready, bus.clear_done} !== 2'b00) begin errors++; $display("FAIL clear_flags_%0d: got %b expected 00", i, {bus.alu_ready, bus.clear_done}); end
        end
        bus.clear_req = 1'b0;
        step();
        checks++; if ({bus.clear_done, bus.write, bus.mem_ready} !== 3'b100) begin errors++; $display("FAIL clear_done_pulse: got %b expected 100", {bus.clear_done, bus.write, bus.mem_ready}); end
        step();
        checks++; if ({bus.clear_done, bus.alu_ready, bus.busy} !== 3'b010) begin errors++; $display("FAIL clear_back_idle: got %b expected 010", {bus.clear_done, bus.alu_ready, bus.busy}); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL clear_no_repeat_%0d: got %b expected 0", i, bus.write); end
        end
    endtask

    task automatic test_clear_reset();
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        checks++; if ({bus.alu_ready, bus.busy, bus.write} !== 3'b010) begin errors++; $display("FAIL clrrst_pending: got %b expected 010", {bus.alu_ready, bus.busy, bus.write}); end
        for (int i = 0; i < 4; i++) begin
            step();
        end
        checks++; if ({bus.write, bus.inaddress} !== {1'b1, 3'd3}) begin errors++; $display("FAIL clrrst_fourth: got w=%b a=%0d expected w=1 a=3", bus.write, bus.inaddress); end
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL clrrst_write: got %b expected 0", bus.write); end
        checks++; if ({bus.alu_ready, bus.mem_ready, bus.busy, bus.clear_done} !== 4'b1100) begin errors++; $display("FAIL clrrst_flags: got %b expected 1100", {bus.alu_ready, bus.mem_ready, bus.busy, bus.clear_done}); end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({bus.write, bus.clear_done} !== 2'b00) begin errors++; $display("FAIL clrrst_after_%0d: got %b expected 00", i, {bus.write, bus.clear_done}); end
        end
    endtask
`else
    task automatic test_clear_disabled();
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        checks++; if ({bus.alu_ready, bus.mem_ready, bus.busy} !== 3'b110) begin errors++; $display("FAIL noclr_ready_busy: got %b expected 110", {bus.alu_ready, bus.mem_ready, bus.busy}); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({bus.write, bus.clear_done, bus.busy} !== 3'b000) begin errors++; $display("FAIL noclr_cycle_%0d: got %b expected 000", i, {bus.write, bus.clear_done, bus.busy}); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_mem_then_alu();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef RWA_CLEAR_SEQ_EN
        test_clear();
        test_clear_reset();
`else
        test_clear_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameters: DATA_W, 8, register data width; ADDR_W, 3, register address width; NREG, 8, register count cleared by the clear sequence.
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 RESET  in  1  reset, asynchronous and active-high.
REQ-004 ALU_REQ / ALU_ADDR / ALU_DATA  in  1/ADDR_W/DATA_W  ALU writeback request, address, data.
REQ-005 ALU_READY  out  1  ALU slot free; transfer when ALU_REQ & ALU_READY at posedge.
REQ-006 MEM_REQ / MEM_ADDR / MEM_DATA  in  1/ADDR_W/DATA_W  memory-load writeback request, address, data.
REQ-007 MEM_READY  out  1  MEM slot free; transfer when MEM_REQ & MEM_READY at posedge.
REQ-008 CLEAR_REQ  in  1  one-cycle pulse requesting zeroing of all registers.
REQ-009 CLEAR_DONE  out  1  one-cycle pulse, clear sequence finished.
REQ-010 WRITE / INADDRESS / IN  out  1/ADDR_W/DATA_W  register-file write port, registered.
REQ-011 BUSY  out  1  any slot pending, clear pending or clear active.

Function
REQ-012 The block SHALL hold one pending entry (valid, addr, data) per requester; READY = ~valid & ~clear_pending & ~clear_active, combinational.
REQ-013 A captured entry SHALL NOT be granted on its capture edge; earliest WRITE is the cycle after the next posedge (capture edge N, WRITE high N+1..N+2).
REQ-014 At most one entry SHALL be granted per posedge; the grant drives WRITE=1, INADDRESS, IN for exactly one cycle and clears that slot's valid.
REQ-015 With both slots valid, the older entry SHALL be granted first; an OLDER flag records capture order; simultaneous capture SHALL count MEM as older.
REQ-016 With no grant, WRITE SHALL be 0; INADDRESS and IN SHALL hold their last values.
REQ-017 FSM states: IDLE, DRAIN, CLEAR, DONE.
REQ-018 IDLE -> DRAIN when any slot is valid; DRAIN -> IDLE when no slot is valid after the grant and no clear is pending.
REQ-019 CLEAR_REQ in any state SHALL set clear_pending; new captures SHALL be blocked from that edge.
REQ-020 IDLE or DRAIN -> CLEAR when clear_pending is set and both slots are empty; clear_pending SHALL then clear.
REQ-021 CLEAR SHALL issue NREG consecutive writes, WRITE=1, IN=0, INADDRESS=0,1,...,NREG-1, one per cycle.
REQ-022 After the write to NREG-1 the FSM SHALL enter DONE for one cycle with CLEAR_DONE=1, then return to IDLE.
REQ-023 CLEAR_REQ during CLEAR or DONE SHALL be ignored.
REQ-024 Address counter width SHALL be ADDR_W; it SHALL NOT wrap past NREG-1.

Reset
REQ-025 Asserting RESET SHALL immediately clear both valid bits, OLDER, clear_pending and the address counter, and set the FSM to IDLE.
REQ-026 Reset values: WRITE=0, INADDRESS=0, IN=0, CLEAR_DONE=0, BUSY=0, ALU_READY=1, MEM_READY=1.
REQ-027 RESET mid-CLEAR or mid-DRAIN SHALL abandon the sequence and discard pending entries; no write SHALL be issued after reset until a new request.

Configuration
REQ-028 Macro RWA_CLEAR_SEQ_EN defined: clear_pending, CLEAR, DONE and CLEAR_DONE behave per REQ-019..REQ-023.
REQ-029 RWA_CLEAR_SEQ_EN undefined: CLEAR_REQ is ignored, CLEAR_DONE is tied 0, CLEAR/DONE states are absent, and READY depends only on slot valid.

Verification
REQ-030 Single ALU_REQ addr 3 data 8'h5A at edge 1 -> WRITE=1, INADDRESS=3, IN=8'h5A during cycle after edge 2 only; ALU_READY low between edges 1 and 2.
REQ-031 ALU and MEM requests at the same edge (addr 2 data 8'h11 / addr 2 data 8'h22) -> MEM write then ALU write on consecutive cycles; final value at addr 2 is 8'h11.
REQ-032 MEM captured at edge 1, ALU at edge 2, with MEM not yet granted -> MEM granted first.
REQ-033 CLEAR_REQ with the ALU slot pending -> ALU write first, then 8 writes of 0 to addr 0..7, then CLEAR_DONE pulse; READY low throughout.
REQ-034 RESET asserted during the 4th clear write -> WRITE drops to 0 without waiting for an edge; no further writes; READY=1.
REQ-035 Build without RWA_CLEAR_SEQ_EN, pulse CLEAR_REQ -> no writes, CLEAR_DONE stays 0, BUSY stays 0.
